// File: rtl/deinterleaver.sv
// Block deinterleaver: accepts ROWS*COLS-symbol blocks in column-major order
// and emits each block in row-major order. Two ping-pong banks let one block
// fill while the other drains, giving one symbol per clock of throughput.
module deinterleaver #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upstream_rdy,
  input  logic [WIDTH-1:0] upstream_data,
  output logic             upstream_acpt,
  output logic             downstream_rdy,
  output logic [WIDTH-1:0] downstream_data,
  input  logic             downstream_acpt
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(N);

  // Storage: two banks, each holding one block in row-major layout
  logic [WIDTH-1:0] r_mem [0:1][0:N-1];
  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [RW-1:0]    r_wr_r;
  logic [CW-1:0]    r_wr_c;
  logic [AW-1:0]    r_rd_a;
  logic             r_v;
  logic [WIDTH-1:0] r_dout;

  logic             w_wr_en;
  logic             w_wr_r_end;
  logic             w_wr_c_end;
  logic             w_wr_last;
  logic [AW-1:0]    w_wr_addr;
  logic             w_load;
  logic             w_rd_last;
  logic             w_read;

  assign upstream_acpt   = ~r_full[r_wr_bank];
  assign downstream_rdy  = r_v;
  assign downstream_data = r_dout;

  assign w_wr_en    = upstream_rdy & upstream_acpt;
  assign w_wr_r_end = (r_wr_r == RW'(ROWS - 1));
  assign w_wr_c_end = (r_wr_c == CW'(COLS - 1));
  assign w_wr_last  = w_wr_en & w_wr_r_end & w_wr_c_end;
  // Column-major input lands at its row-major slot so the read side can scan linearly
  assign w_wr_addr  = AW'(32'(r_wr_r) * COLS + 32'(r_wr_c));

  assign w_load    = r_full[r_rd_bank] & (~r_v | downstream_acpt);
  assign w_rd_last = w_load & (r_rd_a == AW'(N - 1));
  assign w_read    = r_v & downstream_acpt;

  // Bank memory write; contents need no reset since full flags gate every read
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_bank][w_wr_addr] <= upstream_data;
    end
  end

  // Write-side row/column counters and write bank select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_r    <= '0;
      r_wr_c    <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_en) begin
      if (w_wr_r_end) begin
        r_wr_r <= '0;
        if (w_wr_c_end) begin
          r_wr_c    <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_c <= r_wr_c + 1'b1;
        end
      end else begin
        r_wr_r <= r_wr_r + 1'b1;
      end
    end
  end

  // Per-bank full flags; set and clear always address different banks on one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= '0;
    end else begin
      if (w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_last) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Read pointer, read bank select and one-entry output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_a    <= '0;
      r_rd_bank <= 1'b0;
      r_v       <= 1'b0;
      r_dout    <= '0;
    end else if (w_load) begin
      r_dout <= r_mem[r_rd_bank][r_rd_a];
      r_v    <= 1'b1;
      if (w_rd_last) begin
        r_rd_a    <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_a <= r_rd_a + 1'b1;
      end
    end else if (w_read) begin
      r_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver (ROWS=4, COLS=8, WIDTH=8) with a transpose
// scoreboard and output-hold checks.
module tb_deinterleaver;

  localparam int W = 8;
  localparam int R = 4;
  localparam int C = 8;
  localparam int N = R * C;

  logic         clk = 1'b0;
  logic         reset;
  logic         upstream_rdy;
  logic [W-1:0] upstream_data;
  logic         upstream_acpt;
  logic         downstream_rdy;
  logic [W-1:0] downstream_data;
  logic         downstream_acpt;

  always #5 clk = ~clk;

  deinterleaver #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk             (clk),
    .reset           (reset),
    .upstream_rdy    (upstream_rdy),
    .upstream_data   (upstream_data),
    .upstream_acpt   (upstream_acpt),
    .downstream_rdy  (downstream_rdy),
    .downstream_data (downstream_data),
    .downstream_acpt (downstream_acpt)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] blk [N];
  logic [W-1:0] exp_q [$];
  int wr_k;
  int sym;
  int cyc;
  int wr_n, rd_n;
  int first_rdy_cyc, first_rd_cyc, last_rd_cyc, wr64_cyc, rd32_cyc;
  logic         prev_hold;
  logic [W-1:0] prev_data;
  logic         obs_uacpt, obs_drdy;
  logic [W-1:0] obs_ddata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] sym_data(input int s);
    return W'(s * 37 + 11);
  endfunction

  task automatic mark();
    wr_n = 0; rd_n = 0;
    first_rdy_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
    wr64_cyc = -1; rd32_cyc = -1;
  endtask

  // One clock: drive after negedge, sample 1ns later, update the model for the coming edge
  task automatic cycle(input logic urdy, input logic dacpt);
    @(negedge clk);
    upstream_rdy    = urdy;
    upstream_data   = sym_data(sym);
    downstream_acpt = dacpt;
    #1;
    cyc++;
    obs_uacpt = upstream_acpt;
    obs_drdy  = downstream_rdy;
    obs_ddata = downstream_data;
    if (obs_drdy && first_rdy_cyc < 0) first_rdy_cyc = cyc;
    if (prev_hold) begin
      check("hold_rdy", 32'(obs_drdy), 32'd1);
      check("hold_data", 32'(obs_ddata), 32'(prev_data));
    end
    if (obs_drdy && dacpt) begin
      check("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("out_data", 32'(obs_ddata), 32'(exp_q.pop_front()));
      rd_n++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      if (rd_n == 32) rd32_cyc = cyc;
    end
    prev_hold = obs_drdy && !dacpt;
    prev_data = obs_ddata;
    if (urdy && obs_uacpt) begin
      blk[wr_k] = upstream_data;
      wr_k++;
      sym++;
      wr_n++;
      if (wr_n == 64) wr64_cyc = cyc;
      if (wr_k == N) begin
        for (int j = 0; j < N; j++) exp_q.push_back(blk[(j % C) * R + j / C]);
        wr_k = 0;
      end
    end
  endtask

  task automatic run_stream(input int nsym, input int prdy, input int pacpt, input int budget);
    int target;
    int b;
    logic u, a;
    target = wr_n + nsym;
    b = 0;
    while (!(wr_n >= target && exp_q.size() == 0) && b < budget) begin
      u = (wr_n < target) && (int'($urandom_range(99)) < prdy);
      a = int'($urandom_range(99)) < pacpt;
      cycle(u, a);
      b++;
    end
    check("stream_complete", 32'(wr_n >= target && exp_q.size() == 0), 32'd1);
    cycle(1'b0, 1'b1);
    check("idle_after_drain", 32'(obs_drdy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    upstream_rdy    = 1'b0;
    downstream_acpt = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_uacpt", 32'(upstream_acpt), 32'd1);
    check("rst_drdy", 32'(downstream_rdy), 32'd0);
    check("rst_ddata", 32'(downstream_data), 32'd0);
    exp_q.delete();
    wr_k = 0;
    prev_hold = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lastw;
    int b;
    reset = 1'b0;
    upstream_rdy = 1'b0;
    upstream_data = '0;
    downstream_acpt = 1'b0;
    wr_k = 0; sym = 0; cyc = 0; prev_hold = 1'b0; prev_data = '0;
    mark();
    do_reset();

    // Test 1: single block, latency and transpose order
    mark();
    sym = 0;
    for (int k = 0; k < N; k++) cycle(1'b1, 1'b1);
    lastw = cyc;
    check("t1_writes", 32'(wr_n), 32'd32);
    b = 0;
    while (first_rdy_cyc < 0 && b < 10) begin
      cycle(1'b0, 1'b1);
      b++;
    end
    check("t1_latency", 32'(first_rdy_cyc - lastw), 32'd2);
    check("t1_out0", 32'(obs_ddata), 32'd11);
    cycle(1'b0, 1'b1);
    check("t1_out1", 32'(obs_ddata), 32'd159);
    cycle(1'b0, 1'b1);
    check("t1_out2", 32'(obs_ddata), 32'd51);
    run_stream(0, 100, 100, 100);
    check("t1_reads", 32'(rd_n), 32'd32);

    // Test 2: four blocks back to back
    mark();
    for (int i = 0; i < 4 * N; i++) begin
      cycle(1'b1, 1'b1);
      check("t2_uacpt", 32'(obs_uacpt), 32'd1);
    end
    run_stream(0, 100, 100, 200);
    check("t2_reads", 32'(rd_n), 32'd128);
    check("t2_no_gaps", 32'(last_rd_cyc - first_rd_cyc + 1), 32'd128);

    // Test 3: sink stalled, both banks fill, then drain
    do_reset();
    mark();
    for (int i = 0; i < 2 * N; i++) cycle(1'b1, 1'b0);
    check("t3_first64", 32'(wr_n), 32'd64);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      check("t3_uacpt_low", 32'(obs_uacpt), 32'd0);
    end
    check("t3_held_at_64", 32'(wr_n), 32'd64);
    run_stream(32, 100, 100, 400);
    check("t3_reads", 32'(rd_n), 32'd96);

    // Test 4: random gaps on both sides over 20 blocks
    mark();
    run_stream(20 * N, 50, 50, 8000);
    check("t4_reads", 32'(rd_n), 32'd640);

    // Test 5: reset mid-block while the previous block drains
    do_reset();
    mark();
    for (int i = 0; i < N + 13; i++) cycle(1'b1, 1'b1);
    check("t5_draining", 32'(rd_n > 0), 32'd1);
    do_reset();
    mark();
    run_stream(32, 100, 100, 200);
    check("t5_reads", 32'(rd_n), 32'd32);

    // Test 6: last write of one bank coincides with last load of the other
    do_reset();
    mark();
    run_stream(96, 100, 100, 400);
    check("t6_same_edge", 32'(rd32_cyc - wr64_cyc), 32'd1);
    check("t6_reads", 32'(rd_n), 32'd96);
    check("t6_no_gaps", 32'(last_rd_cyc - first_rd_cyc + 1), 32'd96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
